// File: rtl/reg_bank_rw_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_rw_if
// Purpose  : Select/direction/address/acknowledge handshake of reg_bank_rw.
// Revision : 1.0
// ============================================================================
interface reg_bank_rw_if #(
   parameter int ADDR_W = 2
) ();
   logic              Sel;
   logic              RnW;
   logic [ADDR_W-1:0] Addr;
   logic              Ack;

   modport master (output Sel, output RnW, output Addr, input Ack);
   modport slave  (input Sel, input RnW, input Addr, output Ack);
endinterface
`default_nettype wire

// File: rtl/reg_bank_rw.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_rw
// Purpose  : DEPTH x WIDTH register bank on a shared tri-state data bus.
// Revision : 1.0
// ============================================================================
module reg_bank_rw #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2
) (
   input  wire logic             Clk,
   input  wire logic             Rst_n,
   reg_bank_rw_if.slave          bus,
   inout  wire logic [WIDTH-1:0] Dio
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_ACK   = 2'd1,
      RD_DRV   = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;
   logic             w_drive;
   logic             w_start;

   assign w_start = (r_state == IDLE) && bus.Sel;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state   <= IDLE;
         r_rd_data <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         // Address and data are only looked at on the start edge.
         if (w_start) begin
            if (bus.RnW) begin
               r_rd_data <= r_mem[bus.Addr];
            end else begin
               r_mem[bus.Addr] <= Dio;
            end
         end
      end
   end

   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:     w_next = bus.Sel ? (bus.RnW ? RD_DRV : WR_ACK) : IDLE;
         WR_ACK:   w_next = bus.Sel ? WAIT_REL : IDLE;
         RD_DRV: begin
            if (!bus.Sel) begin
               w_next = IDLE;
            end else if (bus.RnW) begin
               w_next = RD_DRV;
            end else begin
               w_next = WAIT_REL;
            end
         end
         WAIT_REL: w_next = bus.Sel ? WAIT_REL : IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Drive enable follows Sel/RnW combinationally so the bus frees in the same cycle.
   assign w_drive = (r_state == RD_DRV) && bus.Sel && bus.RnW;
   assign Dio     = w_drive ? r_rd_data : {WIDTH{1'bz}};
   assign bus.Ack = (r_state == WR_ACK) || (r_state == RD_DRV);

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_rw.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_rw
// Purpose  : Scoreboard bench for reg_bank_rw (8x4 instance plus a 16x8 instance).
// Revision : 1.0
// ============================================================================
module tb_reg_bank_rw;
   logic Clk = 1'b0;
   logic Rst_n;
   always #5 Clk = ~Clk;

   reg_bank_rw_if #(.ADDR_W(2)) bus8 ();
   reg_bank_rw_if #(.ADDR_W(3)) bus16 ();

   wire  [7:0]  Dio8;
   wire  [15:0] Dio16;
   logic        tb_drv;
   logic [7:0]  tb_dio;
   logic        tb_drv16;
   logic [15:0] tb_dio16;

   // Undriven bus reads as all ones, so a floating Dio is distinguishable from data.
   pullup pu8 (Dio8);
   pullup pu16 (Dio16);
   assign Dio8  = tb_drv   ? tb_dio   : 8'hzz;
   assign Dio16 = tb_drv16 ? tb_dio16 : 16'hzzzz;

   reg_bank_rw #(.WIDTH(8), .ADDR_W(2)) u_dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus8),
      .Dio   (Dio8)
   );

   reg_bank_rw #(.WIDTH(16), .ADDR_W(3)) u_dut16 (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus16),
      .Dio   (Dio16)
   );

   typedef struct {
      bit       rd;
      logic [7:0] data;
      int       len;
   } exp_t;

   exp_t       q[$];
   logic [7:0] model [4];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #7;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
   endtask

   // Monitor: every Ack burst consumes one expected transaction.
   initial begin
      int   cnt;
      bit   active;
      exp_t cur;
      cnt = 0;
      active = 0;
      cur.rd = 0; cur.data = 8'h00; cur.len = 0;
      forever begin
         @(negedge Clk);
         if (Rst_n !== 1'b1) begin
            active = 0;
            cnt = 0;
            continue;
         end
         if (bus8.Ack) begin
            if (!active) begin
               if (q.size() == 0) begin
                  check("ack_unexpected", 1, 0);
                  cur.rd = 0; cur.data = 8'h00; cur.len = 0;
               end else begin
                  cur = q.pop_front();
               end
               active = 1;
               cnt = 0;
            end
            cnt++;
            if (cur.rd) check("rd_data", 32'(Dio8), 32'(cur.data));
            else if (!tb_drv) check("wr_ack_dio_z", 32'(Dio8), 32'hFF);
         end else begin
            if (active) begin
               check("ack_len", cnt, cur.len);
               active = 0;
            end
            if (!tb_drv) check("idle_dio_z", 32'(Dio8), 32'hFF);
         end
      end
   end

   // All drivers are called at 7 time units after a rising edge with Sel=0 and the FSM idle.
   task automatic do_read(input int a, input int h, input bit drop_sel);
      exp_t e;
      bus8.Sel  = 1'b1;
      bus8.RnW  = 1'b1;
      bus8.Addr = 2'(a);
      e.rd = 1; e.data = model[a]; e.len = h;
      q.push_back(e);
      repeat (h) begin
         step();
         bus8.Addr = 2'($urandom);
      end
      if (drop_sel) bus8.Sel = 1'b0;
      else          bus8.RnW = 1'b0;
      #1 check("rd_release_z", 32'(Dio8), 32'hFF);
      if (!drop_sel) begin
         repeat ($urandom_range(1, 3)) step();
         bus8.Sel = 1'b0;
      end
      step();
   endtask

   task automatic do_write(input int a, input logic [7:0] d, input int h, input logic [7:0] alt);
      exp_t e;
      bus8.Sel  = 1'b1;
      bus8.RnW  = 1'b0;
      bus8.Addr = 2'(a);
      tb_drv = 1'b1;
      tb_dio = d;
      e.rd = 0; e.data = 8'h00; e.len = 1;
      q.push_back(e);
      model[a] = d;
      step();
      bus8.Addr = 2'($urandom);
      bus8.RnW  = 1'($urandom);
      tb_dio    = alt;
      repeat (h - 1) step();
      bus8.Sel = 1'b0;
      tb_drv   = 1'b0;
      step();
   endtask

   task automatic do_reset_mid(input int a, input bit rd);
      exp_t e;
      bus8.Sel  = 1'b1;
      bus8.RnW  = rd;
      bus8.Addr = 2'(a);
      tb_drv = !rd;
      tb_dio = 8'($urandom);
      e.rd = rd; e.data = model[a]; e.len = 1;
      q.push_back(e);
      step();
      Rst_n = 1'b0;
      #1;
      check("rst_ack", 32'(bus8.Ack), 0);
      if (rd) check("rst_dio_z", 32'(Dio8), 32'hFF);
      tb_drv   = 1'b0;
      bus8.Sel = 1'b0;
      clear_model();
      step();
      Rst_n = 1'b1;
      step();
   endtask

   initial begin
      int a;
      int r;
      Rst_n = 1'b0;
      bus8.Sel = 1'b0; bus8.RnW = 1'b0; bus8.Addr = 2'd0;
      bus16.Sel = 1'b0; bus16.RnW = 1'b0; bus16.Addr = 3'd0;
      tb_drv = 1'b0; tb_dio = 8'h00;
      tb_drv16 = 1'b0; tb_dio16 = 16'h0000;
      clear_model();
      #2;
      check("reset_ack", 32'(bus8.Ack), 0);
      check("reset_dio_z", 32'(Dio8), 32'hFF);
      step();
      step();
      Rst_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++) do_read(i, 1, 1'b1);
      do_write(2, 8'hA5, 1, 8'h00);
      do_read(2, 2, 1'b1);
      do_read(0, 1, 1'b1);
      do_read(1, 1, 1'b1);
      do_read(3, 1, 1'b1);
      do_write(3, 8'h11, 4, 8'h3C);
      do_read(3, 1, 1'b1);
      do_write(1, 8'h5A, 1, 8'hFF);
      do_read(1, 2, 1'b0);
      do_read(1, 1, 1'b1);
      do_reset_mid(1, 1'b1);
      do_read(1, 1, 1'b1);
      do_write(0, 8'h77, 2, 8'h88);
      do_read(0, 3, 1'b0);
      do_reset_mid(0, 1'b0);
      do_read(0, 1, 1'b1);

      for (int i = 0; i < 200; i++) begin
         a = $urandom_range(0, 3);
         r = $urandom_range(0, 39);
         if (r == 0)      do_reset_mid(a, 1'b1);
         else if (r == 1) do_reset_mid(a, 1'b0);
         else if (r < 20) do_write(a, 8'($urandom), $urandom_range(1, 3), 8'($urandom));
         else             do_read(a, $urandom_range(1, 3), 1'($urandom));
      end

      // Wide instance: 16-bit data, eight registers.
      bus16.Sel = 1'b1; bus16.RnW = 1'b0; bus16.Addr = 3'd7;
      tb_drv16 = 1'b1; tb_dio16 = 16'hBEEF;
      step();
      check("w16_wr_ack", 32'(bus16.Ack), 1);
      bus16.Sel = 1'b0; tb_drv16 = 1'b0;
      step();
      check("w16_idle_ack", 32'(bus16.Ack), 0);
      bus16.Sel = 1'b1; bus16.RnW = 1'b1; bus16.Addr = 3'd7;
      step();
      check("w16_rd_ack", 32'(bus16.Ack), 1);
      check("w16_rd7", 32'(Dio16), 32'hBEEF);
      bus16.Sel = 1'b0;
      #1 check("w16_release_z", 32'(Dio16), 32'hFFFF);
      step();
      bus16.Sel = 1'b1; bus16.RnW = 1'b1; bus16.Addr = 3'd0;
      step();
      check("w16_rd0", 32'(Dio16), 32'h0000);
      bus16.Sel = 1'b0;
      step();

      repeat (3) step();
      check("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no completion expected finish before 500000");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/reg_bank_rw.md
REG_BANK_RW -- requirements
Module: reg_bank_rw

Interface
REQ-001 Parameter WIDTH, default 8: data width of each storage register and of Dio.
REQ-002 Parameter ADDR_W, default 2: address width; register count DEPTH = 2**ADDR_W.
REQ-003 Clk  input  1  clock; all state changes occur on its rising edge except reset.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Sel  input  1  transaction select; a transaction starts when Sel=1 in IDLE.
REQ-006 RnW  input  1  direction: 1 = read, 0 = write; sampled with Sel.
REQ-007 Addr  input  ADDR_W  register index; sampled only at transaction start.
REQ-008 Dio  inout  WIDTH  shared data bus; write data in, read data out, Z otherwise.
REQ-009 Ack  output  1  transaction acknowledge, decoded from registered state only.

Function
REQ-010 Storage SHALL be DEPTH registers of WIDTH bits, mem[0..DEPTH-1]; every Addr value is valid.
REQ-011 FSM SHALL have exactly four states: IDLE, WR_ACK, RD_DRV, WAIT_REL.
REQ-012 IDLE, Sel=1, RnW=0 at edge: mem[Addr] <= Dio that edge; next state WR_ACK.
REQ-013 IDLE, Sel=1, RnW=1 at edge: rd_data <= mem[Addr] (snapshot); next state RD_DRV; no register modified.
REQ-014 IDLE, Sel=0: no storage change; stay IDLE.
REQ-015 WR_ACK: Ack=1 for exactly this one cycle; next state WAIT_REL if Sel=1, else IDLE.
REQ-016 RD_DRV: Ack=1; Dio SHALL carry rd_data while Sel=1 and RnW=1; stay while Sel=1 and RnW=1.
REQ-017 RD_DRV, Sel=0 or RnW=0: Dio SHALL go Z combinationally in the same cycle; next state IDLE if Sel=0, WAIT_REL if Sel=1.
REQ-018 WAIT_REL: Ack=0, Dio Z, no storage access; return to IDLE on first edge with Sel=0.
REQ-019 One transaction per Sel assertion: a held Sel SHALL NOT start a second transaction; Sel must be 0 for at least one edge between transactions.
REQ-020 Read latency: data valid on Dio and Ack=1 in the first cycle after the start edge.
REQ-021 Write latency: register updated at the start edge; Ack=1 in the following cycle.
REQ-022 Read of a register written by the immediately preceding transaction SHALL return the new value.
REQ-023 Dio SHALL be driven only in RD_DRV with Sel=1 and RnW=1; a write never causes the block to drive Dio.
REQ-024 Ack SHALL be 0 in IDLE and WAIT_REL; no other output glitches from Addr changes (Addr unused after start edge).
REQ-025 Unused states, if encoded, SHALL recover to IDLE on the next edge with Ack=0 and Dio Z.

Reset
REQ-026 Rst_n=0 SHALL immediately, without Clk: force state IDLE, clear all mem to 0, clear rd_data to 0, Ack=0, Dio Z.
REQ-027 Reset asserted mid-read SHALL release Dio in the same cycle; mid-write SHALL leave the target register 0.
REQ-028 After Rst_n rises, the first edge with Sel=1 in IDLE SHALL start a transaction normally.

Verification
REQ-029 Reset then read each address (WIDTH=8, ADDR_W=2) -> Dio=0x00, Ack=1 one cycle after each start edge.
REQ-030 Write 0xA5 to addr 2, release Sel, read addr 2 -> Ack pulse 1 cycle on write; read Dio=0xA5; mem[0,1,3] still 0x00.
REQ-031 Write with Sel held 4 cycles, Dio changing to 0x3C after first edge -> register holds first-edge value, Ack high 1 cycle, one write only.
REQ-032 Read addr 1 (=0x5A), drop RnW while Sel=1 -> Dio Z same cycle, FSM to WAIT_REL, no write to addr 1.
REQ-033 Rst_n pulsed low during RD_DRV -> Dio Z and Ack=0 immediately; subsequent read returns 0x00.
REQ-034 Parameter sweep WIDTH=16, ADDR_W=3: write 0xBEEF to addr 7, read addr 7 -> 0xBEEF; addr 0 reads 0x0000.
